// File: rtl/ysyx_25030077_operand_seq.sv
// Operand sequencer: accepts one decoded instruction, reads rs1/rs2 through a
// single shared register-file read port, optionally performs a load, and offers
// the two EXU operands until they are consumed. Only one instruction is in
// flight at a time.
//
// Ports:
//   clock, reset            sole clock, synchronous active-high reset
//   io_in_*                 instruction handshake (valid/ready, ctrl, rs1/rs2, imm, pc)
//   io_rf_addr/io_rf_rdata  shared register-file read port (combinational data)
//   io_mem_*                load request handshake and response
//   io_out_*                operand handshake towards the EXU
//   io_err                  sticky load-timeout flag, cleared only by reset
module ysyx_25030077_operand_seq #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [2:0]  io_in_data_control,
  input  logic [4:0]  io_in_rs1_idx,
  input  logic [4:0]  io_in_rs2_idx,
  input  logic [31:0] io_in_imm,
  input  logic [31:0] io_in_pc,
  output logic [4:0]  io_rf_addr,
  input  logic [31:0] io_rf_rdata,
  output logic        io_mem_req_valid,
  input  logic        io_mem_req_ready,
  output logic [31:0] io_mem_addr,
  input  logic        io_mem_resp_valid,
  input  logic [31:0] io_mem_resp_data,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_data_1,
  output logic [31:0] io_out_data_2,
  output logic        io_err
);

  typedef enum logic [2:0] {
    StIdle,
    StRdRs1,
    StRdRs2,
    StMemReq,
    StMemWait,
    StDone
  } state_e;

  localparam logic [2:0] CtrlPcImm  = 3'd1;
  localparam logic [2:0] CtrlLoad   = 3'd2;
  localparam logic [2:0] CtrlRs1Rs2 = 3'd3;

  state_e      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // Ungated versions of the outputs; reset forces every output low below.
  logic        in_ready_c;
  logic [4:0]  rf_addr_c;
  logic        mem_req_c;
  logic [31:0] mem_addr_c;
  logic        out_valid_c;
  logic [31:0] data_1_c, data_2_c;
  logic [31:0] rs_val;

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    in_ready_c  = 1'b0;
    rf_addr_c   = 5'd0;
    mem_req_c   = 1'b0;
    mem_addr_c  = 32'd0;
    out_valid_c = 1'b0;
    data_1_c    = 32'd0;
    data_2_c    = 32'd0;
    rs_val      = 32'd0;

    case (state_q)
      StIdle: begin
        in_ready_c = 1'b1;
        if (io_in_valid) begin
          ctrl_d  = io_in_data_control;
          rs1_d   = io_in_rs1_idx;
          rs2_d   = io_in_rs2_idx;
          imm_d   = io_in_imm;
          pc_d    = io_in_pc;
          op1_d   = 32'd0;
          op2_d   = 32'd0;
          state_d = (io_in_data_control == CtrlPcImm) ? StDone : StRdRs1;
        end
      end
      StRdRs1: begin
        rf_addr_c = rs1_q;
        rs_val    = (rs1_q == 5'd0) ? 32'd0 : io_rf_rdata;
        op1_d     = rs_val;
        unique case (ctrl_q)
          CtrlRs1Rs2: state_d = StRdRs2;
          CtrlLoad: begin
            addr_d  = rs_val + imm_q;
            state_d = StMemReq;
          end
          default: state_d = StDone;
        endcase
      end
      StRdRs2: begin
        rf_addr_c = rs2_q;
        op2_d     = (rs2_q == 5'd0) ? 32'd0 : io_rf_rdata;
        state_d   = StDone;
      end
      StMemReq: begin
        mem_req_c  = 1'b1;
        mem_addr_c = addr_q;
        if (io_mem_req_ready) begin
          cnt_d   = 32'd0;
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        // A response in the same cycle as the timeout takes priority.
        if (io_mem_resp_valid) begin
          op1_d   = io_mem_resp_data;
          state_d = StDone;
        end else if (cnt_q + 32'd1 >= TIMEOUT) begin
          err_d   = 1'b1;
          op1_d   = 32'd0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone: begin
        out_valid_c = 1'b1;
        unique case (ctrl_q)
          CtrlPcImm: begin
            data_1_c = pc_q;
            data_2_c = imm_q;
          end
          CtrlLoad: begin
            data_1_c = op1_q;
            data_2_c = 32'd0;
          end
          CtrlRs1Rs2: begin
            data_1_c = op1_q;
            data_2_c = op2_q;
          end
          default: begin
            data_1_c = op1_q;
            data_2_c = imm_q;
          end
        endcase
        if (io_out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ctrl_q  <= 3'd0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      imm_q   <= 32'd0;
      pc_q    <= 32'd0;
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
      addr_q  <= 32'd0;
      cnt_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // All outputs read as zero during the reset cycle itself.
  assign io_in_ready      = in_ready_c & ~reset;
  assign io_rf_addr       = reset ? 5'd0 : rf_addr_c;
  assign io_mem_req_valid = mem_req_c & ~reset;
  assign io_mem_addr      = reset ? 32'd0 : mem_addr_c;
  assign io_out_valid     = out_valid_c & ~reset;
  assign io_out_data_1    = reset ? 32'd0 : data_1_c;
  assign io_out_data_2    = reset ? 32'd0 : data_2_c;
  assign io_err           = err_q & ~reset;

endmodule

// File: tb/tb_ysyx_25030077_operand_seq.sv
module tb_ysyx_25030077_operand_seq;

  localparam int unsigned Tmo = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [2:0]  io_in_data_control;
  logic [4:0]  io_in_rs1_idx, io_in_rs2_idx;
  logic [31:0] io_in_imm, io_in_pc;
  logic [4:0]  io_rf_addr;
  logic [31:0] io_rf_rdata;
  logic        io_mem_req_valid, io_mem_req_ready;
  logic [31:0] io_mem_addr;
  logic        io_mem_resp_valid;
  logic [31:0] io_mem_resp_data;
  logic        io_out_valid, io_out_ready;
  logic [31:0] io_out_data_1, io_out_data_2;
  logic        io_err;

  ysyx_25030077_operand_seq #(.TIMEOUT(Tmo)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_in_valid        (io_in_valid),
    .io_in_ready        (io_in_ready),
    .io_in_data_control (io_in_data_control),
    .io_in_rs1_idx      (io_in_rs1_idx),
    .io_in_rs2_idx      (io_in_rs2_idx),
    .io_in_imm          (io_in_imm),
    .io_in_pc           (io_in_pc),
    .io_rf_addr         (io_rf_addr),
    .io_rf_rdata        (io_rf_rdata),
    .io_mem_req_valid   (io_mem_req_valid),
    .io_mem_req_ready   (io_mem_req_ready),
    .io_mem_addr        (io_mem_addr),
    .io_mem_resp_valid  (io_mem_resp_valid),
    .io_mem_resp_data   (io_mem_resp_data),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_data_1      (io_out_data_1),
    .io_out_data_2      (io_out_data_2),
    .io_err             (io_err)
  );

  always #5 clock = ~clock;

  // Register file model; index 0 deliberately returns a non-zero value.
  logic [31:0] rf [32];
  assign io_rf_rdata = rf[io_rf_addr];

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    int          lat;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic        err_sticky;
  logic [2:0]  cur_ctrl;
  logic [4:0]  cur_rs1, cur_rs2;
  logic [31:0] cur_addr;
  int          m_req_dly, m_resp_dly;
  bit          m_resp_en;
  logic [31:0] m_resp_data;

  function automatic logic [31:0] rf_val(input logic [4:0] i);
    return (i == 5'd0) ? 32'd0 : rf[i];
  endfunction

  task automatic accept(input logic [2:0] c, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] im, input logic [31:0] p);
    @(negedge clock);
    io_in_valid        = 1'b1;
    io_in_data_control = c;
    io_in_rs1_idx      = r1;
    io_in_rs2_idx      = r2;
    io_in_imm          = im;
    io_in_pc           = p;
    checks++;
    if (io_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_in_ready got %b want 1", io_in_ready);
    end
    @(posedge clock);
    #1 io_in_valid = 1'b0;
  endtask

  // Issues one instruction, pushes its model result, then services memory and
  // the output handshake until the operands are consumed.
  task automatic run_instr(input logic [2:0] c, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] im, input logic [31:0] p,
                           input int req_dly, input int resp_dly, input bit resp_en,
                           input logic [31:0] rdata, input int out_dly);
    exp_t        e;
    int          cyc = 0, req_cnt = 0, wait_cnt = 0, hold = 0;
    bit          hs = 0, done = 0;
    logic [31:0] h1 = 0, h2 = 0;
    logic [4:0]  exp_rf;
    cur_ctrl    = c;
    cur_rs1     = r1;
    cur_rs2     = r2;
    cur_addr    = rf_val(r1) + im;
    m_req_dly   = req_dly;
    m_resp_dly  = resp_dly;
    m_resp_en   = resp_en;
    m_resp_data = rdata;
    case (c)
      3'd1: begin e.d1 = p; e.d2 = im; e.lat = 1; end
      3'd2: begin
        e.d1 = resp_en ? rdata : 32'd0;
        e.d2 = 32'd0;
        e.lat = 1 + (req_dly + 1) + (resp_en ? resp_dly : int'(Tmo)) + 1;
        if (!resp_en) err_sticky = 1'b1;
      end
      3'd3: begin e.d1 = rf_val(r1); e.d2 = rf_val(r2); e.lat = 3; end
      default: begin e.d1 = rf_val(r1); e.d2 = im; e.lat = 2; end
    endcase
    e.err = err_sticky;
    sb.push_back(e);
    accept(c, r1, r2, im, p);
    while (!done && cyc < 400) begin
      @(negedge clock);
      cyc++;
      io_mem_req_ready  = 1'b0;
      io_mem_resp_valid = 1'b0;
      io_out_ready      = 1'b0;
      io_in_valid       = 1'b0;
      if (cyc <= 2) begin
        exp_rf = 5'd0;
        if (cyc == 1 && cur_ctrl != 3'd1) exp_rf = cur_rs1;
        if (cyc == 2 && cur_ctrl == 3'd3) exp_rf = cur_rs2;
        checks++;
        if (io_rf_addr !== exp_rf) begin
          errors++;
          $display("FAIL rf_addr cyc %0d got %0d want %0d", cyc, io_rf_addr, exp_rf);
        end
      end
      if (io_mem_req_valid) begin
        checks++;
        if (io_mem_addr !== cur_addr) begin
          errors++;
          $display("FAIL mem_addr got %h want %h", io_mem_addr, cur_addr);
        end
        req_cnt++;
        io_mem_req_ready = (req_cnt > m_req_dly);
        if (io_mem_req_ready) hs = 1;
      end else if (hs && !io_out_valid) begin
        wait_cnt++;
        if (m_resp_en && wait_cnt == m_resp_dly) begin
          io_mem_resp_valid = 1'b1;
          io_mem_resp_data  = m_resp_data;
        end
      end
      if (!io_out_valid) begin
        checks++;
        if (io_out_data_1 !== 32'd0 || io_out_data_2 !== 32'd0) begin
          errors++;
          $display("FAIL idle_data got %h/%h want 0/0", io_out_data_1, io_out_data_2);
        end
      end else begin
        if (hold == 0) begin
          checks++;
          if (cyc != e.lat) begin
            errors++;
            $display("FAIL latency got %0d want %0d", cyc, e.lat);
          end
          h1 = io_out_data_1;
          h2 = io_out_data_2;
        end else begin
          checks++;
          if (io_out_data_1 !== h1 || io_out_data_2 !== h2 || io_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable got %h/%h rdy %b want %h/%h rdy 0",
                     io_out_data_1, io_out_data_2, io_in_ready, h1, h2);
          end
        end
        hold++;
        if (hold > out_dly) begin
          io_out_ready = 1'b1;
          e = sb.pop_front();
          checks++;
          if (io_out_data_1 !== e.d1 || io_out_data_2 !== e.d2 || io_err !== e.err) begin
            errors++;
            $display("FAIL operands got %h/%h err %b want %h/%h err %b",
                     io_out_data_1, io_out_data_2, io_err, e.d1, e.d2, e.err);
          end
          done = 1;
        end else begin
          // Offer a second instruction while the first is still held.
          io_in_valid        = 1'b1;
          io_in_data_control = 3'd1;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout got none want out_valid within 400 cycles");
      void'(sb.pop_front());
    end
    @(posedge clock);
    #1;
    io_out_ready      = 1'b0;
    io_mem_resp_valid = 1'b0;
    io_mem_req_ready  = 1'b0;
    io_in_valid       = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (io_in_ready !== 1'b0 || io_out_valid !== 1'b0 || io_mem_req_valid !== 1'b0 ||
        io_rf_addr !== 5'd0 || io_mem_addr !== 32'd0 || io_err !== 1'b0 ||
        io_out_data_1 !== 32'd0 || io_out_data_2 !== 32'd0) begin
      errors++;
      $display("FAIL %s got rdy %b ov %b mv %b rf %0d err %b want all 0", tag, io_in_ready,
               io_out_valid, io_mem_req_valid, io_rf_addr, io_err);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_all_zero("reset_outputs");
    reset      = 1'b0;
    err_sticky = 1'b0;
    @(negedge clock);
    checks++;
    if (io_in_ready !== 1'b1 || io_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got rdy %b err %b want rdy 1 err 0", io_in_ready, io_err);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_pc_imm();
    run_instr(3'd1, 5'd7, 5'd9, 32'h10, 32'h8000_0000, 0, 0, 0, 0, 0);
  endtask

  task automatic test_rs1_rs2();
    rf[5] = 32'h11;
    run_instr(3'd3, 5'd5, 5'd0, 32'h1234, 32'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load();
    rf[6] = 32'h1000;
    run_instr(3'd2, 5'd6, 5'd0, 32'hFFFF_FFFC, 32'h0, 2, 3, 1, 32'hDEAD_BEEF, 0);
    run_instr(3'd2, 5'd6, 5'd0, 32'h4, 32'h0, 0, 1, 1, 32'h0BAD_F00D, 0);
  endtask

  task automatic test_backpressure();
    run_instr(3'd0, 5'd3, 5'd4, 32'h55AA, 32'h0, 0, 0, 0, 0, 4);
    @(negedge clock);
    checks++;
    if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake got rdy %b ov %b want 1 0", io_in_ready, io_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ctrls [8];
    ctrls = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3, 3'd1, 3'd2};
    for (int i = 0; i < 8; i++) begin
      run_instr(ctrls[i], 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom,
                $urandom, 0, 1, 1, $urandom, 0);
    end
  endtask

  task automatic test_timeout();
    rf[8] = 32'h2000;
    run_instr(3'd2, 5'd8, 5'd0, 32'h8, 32'h0, 0, 0, 0, 0, 0);
    run_instr(3'd1, 5'd0, 5'd0, 32'h1, 32'h2, 0, 0, 0, 0, 0);
    do_reset();
  endtask

  task automatic test_reset_mid();
    rf[9] = 32'h3000;
    accept(3'd2, 5'd9, 5'd0, 32'h0, 32'h0);
    @(negedge clock);
    @(negedge clock);
    io_mem_req_ready = 1'b1;
    @(negedge clock);
    io_mem_req_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_all_zero("reset_mid_outputs");
    reset             = 1'b0;
    io_mem_resp_valid = 1'b1;
    io_mem_resp_data  = 32'hCAFE_BABE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      io_mem_resp_valid = 1'b0;
      checks++;
      if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0 || io_mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after got rdy %b ov %b mv %b want 1 0 0", io_in_ready,
                 io_out_valid, io_mem_req_valid);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0]              = 32'hFFFF;
    reset              = 1'b1;
    err_sticky         = 1'b0;
    io_in_valid        = 1'b0;
    io_in_data_control = 3'd0;
    io_in_rs1_idx      = 5'd0;
    io_in_rs2_idx      = 5'd0;
    io_in_imm          = 32'd0;
    io_in_pc           = 32'd0;
    io_mem_req_ready   = 1'b0;
    io_mem_resp_valid  = 1'b0;
    io_mem_resp_data   = 32'd0;
    io_out_ready       = 1'b0;
    repeat (2) @(posedge clock);
    test_reset();
    test_pc_imm();
    test_rs1_rs2();
    test_load();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
